cook_controller: RTL
====================

COOK_CONTROLLER -- requirements
Module: cook_controller

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: CLK  in  1  rising-edge clock; Reset  in  1  asynchronous active-high reset.
REQ-002 The block SHALL provide these inputs:
- digit  in  4  keypad BCD digit
- digit_valid  in  1  one-cycle strobe qualifying digit
- start  in  1  one-cycle start/resume strobe
- stop  in  1  one-cycle stop/pause strobe
- clear  in  1  one-cycle clear strobe
- door_closed  in  1  level, 1 = door shut
- sec_tick  in  1  one-cycle 1 Hz pulse
- timer_done  in  1  registered zero flag from the downstream MinutesSecondsTimer
REQ-003 The block SHALL provide these outputs:
- entry_seconds_units  out  4  entered seconds units, to timer initial_seconds_units
- entry_seconds_tens  out  3  entered seconds tens, to timer initial_seconds_tens
- entry_minutes_units  out  4  entered minutes, to timer initial_minutes_units
- Load  out  1  timer load strobe
- Enable  out  1  timer count enable
- Clearn  out  1  active-low timer clear
- mag_on  out  1  magnetron drive
- beep  out  1  done indicator
- entry_error  out  1  one-cycle rejected-digit flag
- state  out  3  FSM state code

Function
REQ-004 The FSM SHALL have these states and codes: IDLE=0, ENTRY=1, LOAD=2, COOK=3, PAUSE=4, DONE=5.
REQ-005 All outputs SHALL be registered; only Enable is a combinational term: COOK AND sec_tick AND door_closed.
REQ-006 Strobes arriving in the same cycle SHALL be resolved by priority: clear, then door open, then stop, then timer_done, then start, then digit_valid.
REQ-007 Digit entry SHALL be accepted only in IDLE or ENTRY, and SHALL shift left: minutes <= seconds_tens, seconds_tens <= seconds_units[2:0], seconds_units <= digit.
REQ-008 A digit SHALL be rejected if digit > 9, or if seconds_units > 5 at the time of the strobe; on rejection, the entry registers are unchanged and entry_error is high for exactly one cycle.
REQ-009 An accepted digit in IDLE SHALL move the FSM to ENTRY.
REQ-010 Digit strobes in all other states SHALL be ignored, without raising entry_error.
REQ-011 Clear in IDLE or ENTRY SHALL zero the entry registers and move the FSM to IDLE.
REQ-012 Start in ENTRY SHALL move the FSM to LOAD only when door_closed=1 and the entered value is nonzero. Otherwise start is ignored.
REQ-013 Start in IDLE SHALL be ignored.
REQ-014 LOAD SHALL last exactly one cycle with Load=1, then move unconditionally to COOK. The entry registers SHALL hold stable while Load=1.
REQ-015 In COOK, mag_on SHALL be 1.
REQ-016 timer_done SHALL be ignored during the first 2 cycles after entering COOK from LOAD, because the timer's flag lags the load by one cycle.
REQ-017 From COOK:
- timer_done (after the guard) -> DONE
- door open or stop -> PAUSE
- clear -> IDLE
REQ-018 In PAUSE, mag_on SHALL be 0 and Enable SHALL be 0.
REQ-019 From PAUSE:
- start with door_closed=1 -> COOK, with no reload and no guard
- stop or clear -> IDLE
REQ-020 In DONE, beep SHALL be 1 and mag_on SHALL be 0.
REQ-021 DONE SHALL return to IDLE after the third sec_tick counted in DONE, or at once on clear, stop or door open. The tick counter SHALL be 2 bits and SHALL reset on DONE entry.
REQ-022 Every transition into IDLE from COOK, PAUSE or DONE SHALL drive Clearn=0 for exactly one cycle and zero the entry registers.
REQ-023 Clearn SHALL be 1 at all other times outside reset.
REQ-024 Entry registers SHALL change only on an accepted digit or a clear path. Minutes are therefore limited to 0-5 by the shift path, and this limit is intended.

Reset
REQ-025 While Reset=1, asynchronously:
- state=IDLE
- all entry registers=0
- Load=0, mag_on=0, beep=0, entry_error=0
- Clearn=0
- DONE tick counter=0
- COOK guard counter=0
REQ-026 Clearn SHALL go to 1 on the first clock edge after Reset deasserts. Reset asserted mid-COOK SHALL drop mag_on in the same cycle, without waiting for a clock edge.

Verification
REQ-027 Digits 1, 3, 0 then start with door closed -> minutes=1, seconds_tens=3, seconds_units=0; Load=1 for exactly one cycle; state LOAD then COOK; mag_on=1.
REQ-028 Digits 7 then 2 -> entry_error=1 for one cycle on the 2; entry is still 0:07. Digit 0xA -> rejected the same way.
REQ-029 COOK with door_closed dropped -> PAUSE next cycle; mag_on=0; Enable=0 even with sec_tick=1. Door closed then start -> COOK with no Load pulse.
REQ-030 Load of 0:02 with timer_done=1 held from the prior zero state -> the FSM stays in COOK through the guard. After 2 sec_ticks and timer_done=1 -> DONE with beep=1; after 3 further sec_ticks -> IDLE with a one-cycle Clearn=0 pulse.
REQ-031 clear and timer_done in the same COOK cycle -> IDLE (clear wins); beep stays 0; Clearn pulses.
REQ-032 Reset pulsed asynchronously between clock edges in COOK -> state=0 and mag_on=0 immediately; Clearn=0 until the first edge after release.

Source files
------------

// File: rtl/cook_controller.sv
//==============================================================================
// Module     : cook_controller
// Description: Microwave cook sequencer: keypad time entry, timer load/enable,
//              magnetron and door interlock, done beep.
// Revision   : 1.0 - initial release
//==============================================================================
`default_nettype none

module cook_controller (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [3:0] digit,
    input  logic       digit_valid,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       door_closed,
    input  logic       sec_tick,
    input  logic       timer_done,
    output logic [3:0] entry_seconds_units,
    output logic [2:0] entry_seconds_tens,
    output logic [3:0] entry_minutes_units,
    output logic       Load,
    output logic       Enable,
    output logic       Clearn,
    output logic       mag_on,
    output logic       beep,
    output logic       entry_error,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        LOAD  = 3'd2,
        COOK  = 3'd3,
        PAUSE = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [1:0] c_GUARD_CYCLES = 2'd2;
    localparam logic [1:0] c_LAST_TICK    = 2'd2;

    state_t     r_state, w_next;
    logic [3:0] r_sec_units, w_sec_units;
    logic [2:0] r_sec_tens,  w_sec_tens;
    logic [3:0] r_minutes,   w_minutes;
    logic [1:0] r_guard,     w_guard;
    logic [1:0] r_ticks,     w_ticks;
    logic       r_load, r_mag_on, r_beep, r_clearn, r_entry_error;
    logic       w_entry_error;
    logic       w_digit_ok;
    logic       w_entry_nz;
    logic       w_abort;

    assign w_digit_ok = (digit <= 4'd9) && (r_sec_units <= 4'd5);
    assign w_entry_nz = (r_sec_units != 4'd0) || (r_sec_tens != 3'd0) || (r_minutes != 4'd0);

    always_comb begin
        w_next        = r_state;
        w_sec_units   = r_sec_units;
        w_sec_tens    = r_sec_tens;
        w_minutes     = r_minutes;
        w_guard       = r_guard;
        w_ticks       = r_ticks;
        w_entry_error = 1'b0;
        w_abort       = 1'b0;

        case (r_state)
            IDLE, ENTRY: begin
                if (clear) begin
                    w_next      = IDLE;
                    w_sec_units = 4'd0;
                    w_sec_tens  = 3'd0;
                    w_minutes   = 4'd0;
                end else if (start) begin
                    if (r_state == ENTRY && door_closed && w_entry_nz)
                        w_next = LOAD;
                end else if (digit_valid) begin
                    if (w_digit_ok) begin
                        w_minutes   = {1'b0, r_sec_tens};
                        w_sec_tens  = r_sec_units[2:0];
                        w_sec_units = digit;
                        w_next      = ENTRY;
                    end else begin
                        w_entry_error = 1'b1;
                    end
                end
            end
            LOAD: begin
                w_next  = COOK;
                w_guard = c_GUARD_CYCLES;
            end
            COOK: begin
                if (r_guard != 2'd0)
                    w_guard = r_guard - 2'd1;
                if (clear) begin
                    w_next = IDLE;
                end else if (!door_closed || stop) begin
                    w_next = PAUSE;
                end else if (timer_done && r_guard == 2'd0) begin
                    w_next  = DONE;
                    w_ticks = 2'd0;
                end
            end
            PAUSE: begin
                if (clear || stop)
                    w_next = IDLE;
                else if (start && door_closed)
                    w_next = COOK;
            end
            DONE: begin
                if (clear || stop || !door_closed) begin
                    w_next = IDLE;
                end else if (sec_tick) begin
                    if (r_ticks == c_LAST_TICK)
                        w_next = IDLE;
                    else
                        w_ticks = r_ticks + 2'd1;
                end
            end
            default: w_next = IDLE;
        endcase

        // Abandoning a cook cycle clears the downstream timer and the entry.
        if (w_next == IDLE && (r_state == COOK || r_state == PAUSE || r_state == DONE)) begin
            w_abort     = 1'b1;
            w_sec_units = 4'd0;
            w_sec_tens  = 3'd0;
            w_minutes   = 4'd0;
        end

        // Guard only applies to a fresh load; a resume from PAUSE starts with none.
        if (w_next != COOK && r_state != LOAD)
            w_guard = 2'd0;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state       <= IDLE;
            r_sec_units   <= 4'd0;
            r_sec_tens    <= 3'd0;
            r_minutes     <= 4'd0;
            r_guard       <= 2'd0;
            r_ticks       <= 2'd0;
            r_load        <= 1'b0;
            r_mag_on      <= 1'b0;
            r_beep        <= 1'b0;
            r_clearn      <= 1'b0;
            r_entry_error <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_sec_units   <= w_sec_units;
            r_sec_tens    <= w_sec_tens;
            r_minutes     <= w_minutes;
            r_guard       <= w_guard;
            r_ticks       <= w_ticks;
            r_load        <= (w_next == LOAD);
            r_mag_on      <= (w_next == COOK);
            r_beep        <= (w_next == DONE);
            r_clearn      <= !w_abort;
            r_entry_error <= w_entry_error;
        end
    end

    assign entry_seconds_units = r_sec_units;
    assign entry_seconds_tens  = r_sec_tens;
    assign entry_minutes_units = r_minutes;
    assign Load                = r_load;
    assign Enable              = (r_state == COOK) && sec_tick && door_closed;
    assign Clearn              = r_clearn;
    assign mag_on              = r_mag_on;
    assign beep                = r_beep;
    assign entry_error         = r_entry_error;
    assign state               = r_state;

endmodule

`default_nettype wire
